cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: picks one completed functional-unit result per cycle and broadcasts it from a registered stage.
// Define CDB_RR_EN for round-robin arbitration; otherwise the lowest valid index wins.
module cdb_arbiter #(
    parameter int               NREQ     = 4,
    parameter int               TAG_W    = 6,
    parameter int               DATA_W   = 32,
    parameter logic [TAG_W-1:0] TAG_NONE = 6'b010000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*TAG_W-1:0]    req_tag,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     cdb_stall,
    input  logic                     flush,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data
);

    // Handshake: requester i transfers on a rising edge where req_valid[i] && req_ready[i];
    // the result is on the bus the following cycle and stays there while cdb_stall is high.

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;

    logic              grant_found;
    logic [PTR_W-1:0]  grant_idx;
    logic              stage_free;
    logic              take;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_data;

`ifdef CDB_RR_EN
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    // Search starts at the pointer and wraps, so the last winner has lowest priority next time.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] idx_p;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_p       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx   = (int'(rr_ptr_q) + k) % NREQ;
            idx_p = PTR_W'(idx);
            if (!grant_found && req_valid[idx_p]) begin
                grant_found = 1'b1;
                grant_idx   = idx_p;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (take) begin
            rr_ptr_d = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        logic [PTR_W-1:0] k_p;
        grant_found = 1'b0;
        grant_idx   = '0;
        k_p         = '0;
        for (int k = 0; k < NREQ; k++) begin
            k_p = PTR_W'(k);
            if (!grant_found && req_valid[k_p]) begin
                grant_found = 1'b1;
                grant_idx   = k_p;
            end
        end
    end
`endif

    assign stage_free = !cdb_valid_q || !cdb_stall;
    assign take       = grant_found && stage_free && !flush;
    assign sel_tag    = req_tag[int'(grant_idx)*TAG_W +: TAG_W];
    assign sel_data   = req_data[int'(grant_idx)*DATA_W +: DATA_W];

    always_comb begin
        req_ready = '0;
        if (take) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // A granted TAG_NONE result is consumed but leaves the stage empty.
    always_comb begin
        cdb_valid_d = cdb_valid_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        if (flush || stage_free) begin
            if (take && (sel_tag != TAG_NONE)) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = sel_tag;
                cdb_data_d  = sel_data;
            end else begin
                cdb_valid_d = 1'b0;
                cdb_tag_d   = TAG_NONE;
                cdb_data_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= TAG_NONE;
            cdb_data_q  <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;

endmodule
